mii_rx_deframer: RTL and testbench

MII_RX_DEFRAMER -- requirements
Module: mii_rx_deframer

---
 rtl/mii_rx_deframer.sv | 140 ++++++++++++++
 tb/tb_mii_rx_deframer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mii_rx_deframer.sv
// MII receive deframer: strips preamble/SFD, assembles nibbles into bytes and
// reports per-frame status (CRC, length, alignment, rx_er) with an eof strobe.
module mii_rx_deframer #(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  rxd,
    input  logic        rx_dv,
    input  logic        rx_er,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        sof,
    output logic        eof,
    output logic        frame_ok,
    output logic [3:0]  status,
    output logic [10:0] byte_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DISCARD} state_t;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
    localparam logic [10:0] MIN_L       = 11'(MIN_LEN);
    localparam logic [10:0] MAX_L       = 11'(MAX_LEN);
    localparam logic [10:0] CNT_SAT     = 11'h7FF;

    state_t      state;
    logic [3:0]  lo_nib;
    logic        have_lo;
    logic [31:0] crc;
    logic [10:0] cnt;
    logic        rxer;
    logic        first;

    logic [7:0]  byte_in;
    logic [31:0] crc_next;
    logic        crc_bad;
    logic        len_bad;
    logic        rxer_any;

    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    // Status terms are evaluated on the rx_dv=0 cycle so they can be registered with eof.
    always_comb begin
        byte_in  = {rxd, lo_nib};
        crc_next = crc_byte(crc, byte_in);
        crc_bad  = (crc != CRC_RESIDUE);
        len_bad  = (cnt < MIN_L) || (cnt > MAX_L);
        rxer_any = rxer | rx_er;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= DISCARD;
            lo_nib     <= 4'h0;
            have_lo    <= 1'b0;
            crc        <= 32'hFFFFFFFF;
            cnt        <= 11'd0;
            rxer       <= 1'b0;
            first      <= 1'b0;
            data_out   <= 8'h00;
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            frame_ok   <= 1'b0;
            status     <= 4'h0;
            byte_cnt   <= 11'd0;
        end else begin
            data_valid <= 1'b0;
            sof        <= 1'b0;
            eof        <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_dv) begin
                        state <= (rxd == 4'h5) ? PREAMBLE : DISCARD;
                    end
                end
                PREAMBLE: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end else if (rxd == 4'hD) begin
                        state   <= DATA;
                        crc     <= 32'hFFFFFFFF;
                        cnt     <= 11'd0;
                        have_lo <= 1'b0;
                        rxer    <= 1'b0;
                        first   <= 1'b1;
                    end else if (rxd != 4'h5) begin
                        state <= DISCARD;
                    end
                end
                DATA: begin
                    if (rx_dv) begin
                        rxer <= rxer_any;
                        if (!have_lo) begin
                            lo_nib  <= rxd;
                            have_lo <= 1'b1;
                        end else begin
                            have_lo    <= 1'b0;
                            data_out   <= byte_in;
                            data_valid <= 1'b1;
                            sof        <= first;
                            first      <= 1'b0;
                            crc        <= crc_next;
                            if (cnt != CNT_SAT) begin
                                cnt <= cnt + 11'd1;
                            end
                        end
                    end else begin
                        // An unpaired low nibble is simply dropped; it only flags align_err.
                        state   <= IDLE;
                        have_lo <= 1'b0;
                        if (cnt != 11'd0) begin
                            eof      <= 1'b1;
                            status   <= {crc_bad, len_bad, have_lo, rxer_any};
                            frame_ok <= ~(crc_bad | len_bad | have_lo | rxer_any);
                            byte_cnt <= cnt;
                        end
                    end
                end
                DISCARD: begin
                    if (!rx_dv) begin
                        state <= IDLE;
                    end
                end
                default: state <= DISCARD;
            endcase
        end
    end

endmodule

// File: tb/tb_mii_rx_deframer.sv
// Self-checking bench for mii_rx_deframer: table of frames driven nibble-wise,
// expected bytes and eof records queued at drive time and popped by a monitor.
module tb_mii_rx_deframer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  rxd = 4'h0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        sof;
    logic        eof;
    logic        frame_ok;
    logic [3:0]  status;
    logic [10:0] byte_cnt;

    always #5 clk = ~clk;

    mii_rx_deframer #(.MIN_LEN(64), .MAX_LEN(1518)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxd        (rxd),
        .rx_dv      (rx_dv),
        .rx_er      (rx_er),
        .data_out   (data_out),
        .data_valid (data_valid),
        .sof        (sof),
        .eof        (eof),
        .frame_ok   (frame_ok),
        .status     (status),
        .byte_cnt   (byte_cnt)
    );

    typedef struct {
        logic [7:0] data;
        logic       first;
    } exp_byte_t;

    typedef struct {
        logic [3:0]  status;
        logic        ok;
        logic [10:0] cnt;
    } exp_eof_t;

    typedef struct {
        string       name;
        int          len;
        bit          bad_fcs;
        bit          extra_nib;
        int          er_byte;
        int          gap;
        logic [3:0]  exp_status;
        logic [10:0] exp_cnt;
    } vec_t;

    exp_byte_t byte_q[$];
    exp_eof_t  eof_q[$];
    int        total = 0;
    int        bad = 0;
    logic      prev_dv = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic reportUnexpected(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: output seen with nothing expected", name);
    endtask

    // Bit-serial reference CRC (reflected, poly 0xEDB88320).
    function automatic logic [31:0] crcModel(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    always @(negedge clk) begin : monitor
        exp_byte_t eb;
        exp_eof_t  ee;
        if (data_valid) begin
            checkOutput("dv_back_to_back", prev_dv, 0);
            if (byte_q.size() == 0) begin
                reportUnexpected("data_valid");
            end else begin
                eb = byte_q.pop_front();
                checkOutput("data_out", data_out, eb.data);
                checkOutput("sof", sof, eb.first);
            end
        end else if (sof) begin
            reportUnexpected("sof_without_dv");
        end
        if (eof) begin
            if (eof_q.size() == 0) begin
                reportUnexpected("eof");
            end else begin
                ee = eof_q.pop_front();
                checkOutput("status", status, ee.status);
                checkOutput("frame_ok", frame_ok, ee.ok);
                checkOutput("byte_cnt", byte_cnt, ee.cnt);
            end
        end
        prev_dv <= data_valid;
    end

    task automatic driveNib(input logic [3:0] d, input logic dv, input logic er);
        @(negedge clk);
        rxd   = d;
        rx_dv = dv;
        rx_er = er;
    endtask

    task automatic sendPreamble();
        for (int i = 0; i < 15; i++) driveNib(4'h5, 1'b1, 1'b0);
        driveNib(4'hD, 1'b1, 1'b0);
    endtask

    task automatic applyStimulus(input vec_t v);
        logic [7:0]  fr[$];
        logic [31:0] c;
        logic [31:0] fcs;
        exp_eof_t    ee;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < v.len - 4; i++) begin
            fr.push_back((i < 6) ? 8'hFF : 8'(i * 37 + 11));
            c = crcModel(c, fr[i]);
        end
        fcs = ~c;
        for (int k = 0; k < 4; k++) fr.push_back(fcs[8*k +: 8]);
        if (v.bad_fcs) fr[v.len - 4] = ~fr[v.len - 4];
        for (int i = 0; i < v.len; i++) byte_q.push_back('{data: fr[i], first: (i == 0)});
        ee.status = v.exp_status;
        ee.ok     = (v.exp_status == 4'h0);
        ee.cnt    = v.exp_cnt;
        eof_q.push_back(ee);
        $display("[TB] frame %s len=%0d", v.name, v.len);
        sendPreamble();
        for (int i = 0; i < v.len; i++) begin
            driveNib(fr[i][3:0], 1'b1, (i == v.er_byte));
            driveNib(fr[i][7:4], 1'b1, 1'b0);
        end
        if (v.extra_nib) driveNib(4'hA, 1'b1, 1'b0);
        for (int g = 0; g < v.gap; g++) driveNib(4'h0, 1'b0, 1'b0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{"good64",    64, 0, 0, -1, 4, 4'b0000, 11'd64};
        vecs[1] = '{"badfcs",    64, 1, 0, -1, 4, 4'b1000, 11'd64};
        vecs[2] = '{"short40",   40, 0, 0, -1, 4, 4'b0100, 11'd40};
        vecs[3] = '{"long1600", 1600, 0, 0, -1, 4, 4'b0100, 11'd1600};
        vecs[4] = '{"rxer",      64, 0, 0, 20, 4, 4'b0001, 11'd64};
        vecs[5] = '{"align",     64, 0, 1, -1, 4, 4'b0010, 11'd64};
        vecs[6] = '{"b2b_a",    100, 0, 0, -1, 1, 4'b0000, 11'd100};
        vecs[7] = '{"b2b_b",    100, 0, 0, -1, 4, 4'b0000, 11'd100};

        repeat (3) @(negedge clk);
        checkOutput("rst_data_valid", data_valid, 0);
        checkOutput("rst_data_out", data_out, 0);
        checkOutput("rst_sof", sof, 0);
        checkOutput("rst_eof", eof, 0);
        checkOutput("rst_frame_ok", frame_ok, 0);
        checkOutput("rst_status", status, 0);
        checkOutput("rst_byte_cnt", byte_cnt, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int n = 0; n < 8; n++) applyStimulus(vecs[n]);

        // Reset mid-frame, released while rx_dv is still high: remainder must be dropped.
        sendPreamble();
        for (int i = 0; i < 10; i++) begin
            byte_q.push_back('{data: 8'(i + 8'h30), first: (i == 0)});
            driveNib(4'(i), 1'b1, 1'b0);
            driveNib(4'h3, 1'b1, 1'b0);
        end
        @(negedge clk);
        reset = 1'b1;
        rxd   = 4'h3;
        rx_dv = 1'b1;
        @(negedge clk);
        checkOutput("midrst_byte_cnt", byte_cnt, 0);
        checkOutput("midrst_status", status, 0);
        checkOutput("midrst_data_valid", data_valid, 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) driveNib(4'h7, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) driveNib(4'h0, 1'b0, 1'b0);

        // Frame with SFD but no data: eof must be suppressed.
        sendPreamble();
        driveNib(4'h4, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) driveNib(4'h0, 1'b0, 1'b0);

        // Corrupt preamble nibble: the rest of the burst is discarded.
        driveNib(4'h5, 1'b1, 1'b0);
        driveNib(4'h5, 1'b1, 1'b0);
        driveNib(4'h3, 1'b1, 1'b0);
        driveNib(4'hD, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) driveNib(4'h9, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) driveNib(4'h0, 1'b0, 1'b0);

        applyStimulus(vecs[0]);

        repeat (10) @(negedge clk);
        checkOutput("bytes_left", byte_q.size(), 0);
        checkOutput("eofs_left", eof_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
